// File: rtl/fetch_sequencer_if.sv
// Instruction-cache request/response port between the fetch sequencer and the I$.
interface fetch_sequencer_if #(
   parameter int unsigned VLEN = 39
) ();
   logic            req;
   logic [VLEN-1:0] vaddr;
   logic            ready;
   logic            kill;
   logic            rsp_valid;

   modport master (output req, output vaddr, output kill, input ready, input rsp_valid);
   modport slave  (input req, input vaddr, input kill, output ready, output rsp_valid);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-PC owner: issues one I$ request at a time, applies redirects,
// replays responses the instruction queue cannot take, and counts stall cycles.
module fetch_sequencer #(
   parameter int unsigned VLEN        = 39,
   parameter int unsigned FETCH_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [VLEN-1:0]         boot_addr_i,
   input  logic                    flush_i,
   input  logic [VLEN-1:0]         flush_pc_i,
   input  logic                    mispredict_i,
   input  logic [VLEN-1:0]         mispredict_pc_i,
   input  logic                    bp_taken_i,
   input  logic [VLEN-1:0]         bp_target_i,
   input  logic                    queue_ready_i,
   fetch_sequencer_if.master       icache,
   output logic                    fetch_valid_o,
   output logic [VLEN-1:0]         fetch_addr_o,
   output logic                    replay_o,
   output logic                    spec_o,
   input  logic                    perf_clear_i,
   output logic [31:0]             stall_cnt_o
);
   localparam int unsigned FB  = FETCH_WIDTH / 8;
   localparam int unsigned OFF = $clog2(FB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e          state_q, state_d;
   logic [VLEN-1:0] pc_q, pc_d;
   logic            spec_q, spec_d;
   logic [31:0]     stall_cnt_q;

   logic            redirect;
   logic [VLEN-1:0] redirect_pc;
   logic [VLEN-1:0] seq_pc;
   logic            req_c, kill_c, fetch_valid_c, replay_c, stall_inc_c;

   assign redirect    = flush_i | mispredict_i;
   assign redirect_pc = flush_i ? flush_pc_i : mispredict_pc_i;
   // Sequential PC always advances from the block-aligned base, wrapping at 2^VLEN.
   assign seq_pc      = {pc_q[VLEN-1:OFF], OFF'(0)} + VLEN'(FB);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= boot_addr_i;
         spec_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         spec_q  <= spec_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      spec_d        = spec_q;
      req_c         = 1'b0;
      kill_c        = 1'b0;
      fetch_valid_c = 1'b0;
      replay_c      = 1'b0;
      stall_inc_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (redirect)           pc_d    = redirect_pc;
            else if (queue_ready_i) state_d = REQ;
         end
         REQ: begin
            req_c = !redirect;
            if (redirect)              pc_d        = redirect_pc;
            else if (icache.ready)     state_d     = WAIT;
            else                       stall_inc_c = 1'b1;
         end
         WAIT: begin
            if (redirect) begin
               // Killed request: any same-cycle response is dropped.
               kill_c  = 1'b1;
               pc_d    = redirect_pc;
               state_d = REQ;
            end else if (icache.rsp_valid && queue_ready_i) begin
               fetch_valid_c = 1'b1;
               pc_d          = bp_taken_i ? bp_target_i : seq_pc;
               if (bp_taken_i) spec_d = 1'b1;
               state_d       = REQ;
            end else if (icache.rsp_valid) begin
               replay_c = 1'b1;
               state_d  = IDLE;
            end else begin
               stall_inc_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect) spec_d = 1'b0;
   end

   // Saturating stall counter; clear wins over increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || perf_clear_i)                  stall_cnt_q <= '0;
      else if (stall_inc_c && stall_cnt_q != '1)  stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   // Handshake strobes are held low while reset is applied.
   assign icache.req    = req_c & !rst_i;
   assign icache.kill   = kill_c & !rst_i;
   assign icache.vaddr  = pc_q;
   assign fetch_valid_o = fetch_valid_c & !rst_i;
   assign replay_o      = replay_c & !rst_i;
   assign fetch_addr_o  = pc_q;
   assign spec_o        = spec_q;
   assign stall_cnt_o   = stall_cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized check of fetch_sequencer against a transaction-level model.
module tb_fetch_sequencer;
   localparam int unsigned VLEN        = 39;
   localparam int unsigned FETCH_WIDTH = 32;
   localparam int unsigned FB          = FETCH_WIDTH / 8;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic [VLEN-1:0] boot_addr_i = VLEN'(64'h80);
   logic            flush_i = 1'b0, mispredict_i = 1'b0, bp_taken_i = 1'b0;
   logic [VLEN-1:0] flush_pc_i = '0, mispredict_pc_i = '0, bp_target_i = '0;
   logic            queue_ready_i = 1'b1, perf_clear_i = 1'b0;
   logic            fetch_valid_o, replay_o, spec_o;
   logic [VLEN-1:0] fetch_addr_o;
   logic [31:0]     stall_cnt_o;

   fetch_sequencer_if #(.VLEN(VLEN)) ic ();

   fetch_sequencer #(.VLEN(VLEN), .FETCH_WIDTH(FETCH_WIDTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .boot_addr_i(boot_addr_i),
      .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .mispredict_i(mispredict_i), .mispredict_pc_i(mispredict_pc_i),
      .bp_taken_i(bp_taken_i), .bp_target_i(bp_target_i),
      .queue_ready_i(queue_ready_i), .icache(ic.master),
      .fetch_valid_o(fetch_valid_o), .fetch_addr_o(fetch_addr_o),
      .replay_o(replay_o), .spec_o(spec_o),
      .perf_clear_i(perf_clear_i), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned vectors = 0, miscompares = 0;

   // Model: fetching enabled, request outstanding, current PC, speculation flag, stall count.
   bit              m_active, m_pending, m_spec;
   logic [VLEN-1:0] m_pc;
   longint unsigned m_cnt;
   bit              auto_cache = 1'b1;
   logic [VLEN-1:0] issued[$];
   int unsigned     fv_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] next_seq(input logic [VLEN-1:0] pc);
      longint unsigned p;
      p = 64'(pc);
      p = (p / FB) * FB + FB;
      return VLEN'(p % (64'd1 << VLEN));
   endfunction

   function automatic logic [VLEN-1:0] rnd_addr();
      return VLEN'({$urandom, $urandom});
   endfunction

   // One clock: check outputs against the model, then advance the model across the edge.
   task automatic tick();
      bit redir, e_req, e_kill, e_fv, e_rep, stall;
      logic [VLEN-1:0] rpc;
      if (auto_cache) ic.rsp_valid = m_pending;
      #1;
      redir  = flush_i | mispredict_i;
      rpc    = flush_i ? flush_pc_i : mispredict_pc_i;
      e_req  = !rst_i && m_active && !m_pending && !redir;
      e_kill = !rst_i && m_pending && redir;
      e_fv   = !rst_i && m_pending && !redir && ic.rsp_valid && queue_ready_i;
      e_rep  = !rst_i && m_pending && !redir && ic.rsp_valid && !queue_ready_i;
      chk("req",        64'(ic.req),        64'(e_req));
      chk("kill",       64'(ic.kill),       64'(e_kill));
      chk("fetch_valid",64'(fetch_valid_o), 64'(e_fv));
      chk("replay",     64'(replay_o),      64'(e_rep));
      chk("vaddr",      64'(ic.vaddr),      64'(m_pc));
      chk("fetch_addr", 64'(fetch_addr_o),  64'(m_pc));
      chk("spec",       64'(spec_o),        64'(m_spec));
      chk("stall_cnt",  64'(stall_cnt_o),   m_cnt);
      if (fetch_valid_o) fv_cnt++;
      if (e_req && ic.ready) issued.push_back(m_pc);
      if (rst_i) begin
         m_active = 0; m_pending = 0; m_pc = boot_addr_i; m_spec = 0; m_cnt = 0;
      end else begin
         stall = (e_req && ic.ready == 1'b0) || (m_pending && !ic.rsp_valid && !redir);
         if (perf_clear_i) m_cnt = 0;
         else if (stall && m_cnt != 64'hFFFF_FFFF) m_cnt++;
         if (redir) begin
            m_pc = rpc; m_spec = 0; m_pending = 0;
         end else if (!m_active) begin
            if (queue_ready_i) m_active = 1;
         end else if (!m_pending) begin
            if (ic.ready) m_pending = 1;
         end else if (ic.rsp_valid) begin
            m_pending = 0;
            if (queue_ready_i) begin
               m_pc = bp_taken_i ? bp_target_i : next_seq(m_pc);
               if (bp_taken_i) m_spec = 1;
            end else begin
               m_active = 0;
            end
         end
      end
      @(negedge clk_i);
   endtask

   initial begin
      ic.ready = 1'b1; ic.rsp_valid = 1'b0;
      // Reset, then confirm the reset state before any model-driven cycle.
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      m_active = 0; m_pending = 0; m_pc = boot_addr_i; m_spec = 0; m_cnt = 0;
      chk("rst_vaddr", 64'(ic.vaddr), 64'h80);
      chk("rst_spec",  64'(spec_o), 64'h0);
      chk("rst_stall", 64'(stall_cnt_o), 64'h0);
      chk("rst_req",   64'(ic.req), 64'h0);
      tick();
      rst_i = 1'b0;

      // Streaming fetch from boot with a 1-cycle cache.
      issued.delete();
      tick();
      fv_cnt = 0;
      repeat (6) tick();
      chk("seq0", 64'(issued[0]), 64'h80);
      chk("seq1", 64'(issued[1]), 64'h84);
      chk("seq2", 64'(issued[2]), 64'h88);
      chk("fv_every_2nd", 64'(fv_cnt), 64'd3);

      // Unaligned PC rounds down before advancing; top block wraps to zero.
      flush_i = 1'b1; flush_pc_i = VLEN'(64'h82); tick(); flush_i = 1'b0;
      tick(); tick();
      chk("unaligned_next", 64'(ic.vaddr), 64'h84);
      flush_i = 1'b1; flush_pc_i = VLEN'((64'd1 << VLEN) - 64'd4); tick(); flush_i = 1'b0;
      tick(); tick();
      chk("wrap_next", 64'(ic.vaddr), 64'h0);

      // Predicted-taken branch.
      tick();
      bp_taken_i = 1'b1; bp_target_i = VLEN'(64'h300); tick(); bp_taken_i = 1'b0;
      chk("bp_spec",  64'(spec_o), 64'h1);
      chk("bp_vaddr", 64'(ic.vaddr), 64'h300);

      // Mispredict in WAIT with a same-cycle response.
      tick();
      auto_cache = 1'b0; ic.rsp_valid = 1'b1;
      mispredict_i = 1'b1; mispredict_pc_i = VLEN'(64'h200);
      #1;
      chk("misp_kill", 64'(ic.kill), 64'h1);
      chk("misp_fv",   64'(fetch_valid_o), 64'h0);
      tick();
      mispredict_i = 1'b0; auto_cache = 1'b1; ic.rsp_valid = 1'b0;
      #1;
      chk("misp_req",   64'(ic.req), 64'h1);
      chk("misp_vaddr", 64'(ic.vaddr), 64'h200);
      chk("misp_spec",  64'(spec_o), 64'h0);

      // Simultaneous flush and mispredict in REQ: flush wins, no handshake.
      flush_i = 1'b1; flush_pc_i = VLEN'(64'h100);
      mispredict_i = 1'b1; mispredict_pc_i = VLEN'(64'h200);
      #1;
      chk("both_noreq", 64'(ic.req), 64'h0);
      tick();
      flush_i = 1'b0; mispredict_i = 1'b0;
      #1;
      chk("both_vaddr", 64'(ic.vaddr), 64'h100);
      chk("both_req",   64'(ic.req), 64'h1);

      // Replay when the queue cannot take the response.
      flush_i = 1'b1; flush_pc_i = VLEN'(64'h40); tick(); flush_i = 1'b0;
      tick();
      auto_cache = 1'b0; ic.rsp_valid = 1'b1; queue_ready_i = 1'b0;
      #1;
      chk("replay", 64'(replay_o), 64'h1);
      tick();
      ic.rsp_valid = 1'b0;
      repeat (2) tick();
      queue_ready_i = 1'b1;
      tick();
      auto_cache = 1'b1;
      #1;
      chk("replay_req",   64'(ic.req), 64'h1);
      chk("replay_vaddr", 64'(ic.vaddr), 64'h40);

      // Stall counting, clear, saturation.
      ic.ready = 1'b0; perf_clear_i = 1'b1; tick(); perf_clear_i = 1'b0;
      repeat (5) tick();
      chk("stall5", 64'(stall_cnt_o), 64'd5);
      perf_clear_i = 1'b1; tick(); perf_clear_i = 1'b0;
      chk("clear", 64'(stall_cnt_o), 64'd0);
      force dut.stall_cnt_q = 32'hFFFF_FFFD;
      #1;
      release dut.stall_cnt_q;
      m_cnt = 64'hFFFF_FFFD;
      repeat (3) tick();
      chk("saturate", 64'(stall_cnt_o), 64'hFFFF_FFFF);
      perf_clear_i = 1'b1; tick(); perf_clear_i = 1'b0;
      chk("sat_clear", 64'(stall_cnt_o), 64'd0);

      // Randomized traffic; cache answers only outstanding requests.
      auto_cache = 1'b0;
      for (int i = 0; i < 600; i++) begin
         rst_i           = ($urandom_range(0, 199) == 0);
         boot_addr_i     = rnd_addr();
         flush_i         = ($urandom_range(0, 15) == 0);
         flush_pc_i      = rnd_addr();
         mispredict_i    = ($urandom_range(0, 11) == 0);
         mispredict_pc_i = rnd_addr();
         bp_taken_i      = ($urandom_range(0, 3) == 0);
         bp_target_i     = ($urandom_range(0, 7) == 0) ? VLEN'((64'd1 << VLEN) - 64'd4) : rnd_addr();
         queue_ready_i   = ($urandom_range(0, 3) != 0);
         ic.ready        = $urandom_range(0, 1) == 1;
         ic.rsp_valid    = m_pending && ($urandom_range(0, 2) != 0);
         perf_clear_i    = ($urandom_range(0, 31) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
